// File: rtl/ping_if.sv
// Handshake/result bundle between a ping controller and ping_sequencer.
// The master side drives the carriers and controls; the slave side is the sequencer.
interface ping_if #(
  parameter int unsigned NUM_TRANSMITTERS = 4,
  parameter int unsigned TOF_WIDTH        = 32
);
  logic [NUM_TRANSMITTERS-1:0] tx_in;
  logic                        trigger_in;
  logic                        abort_in;
  logic                        rx_echo_in;
  logic [NUM_TRANSMITTERS-1:0] tx_out;
  logic                        busy_out;
  logic [TOF_WIDTH-1:0]        tof_out;
  logic                        tof_valid_out;
  logic                        tof_timeout_out;

  modport master (
    output tx_in, trigger_in, abort_in, rx_echo_in,
    input  tx_out, busy_out, tof_out, tof_valid_out, tof_timeout_out
  );

  modport slave (
    input  tx_in, trigger_in, abort_in, rx_echo_in,
    output tx_out, busy_out, tof_out, tof_valid_out, tof_timeout_out
  );
endinterface

// File: rtl/ping_sequencer.sv
// Gates beamformer carriers into bursts (burst -> guard -> listen) and reports echo time-of-flight.
// Define PING_AUTO_REPEAT_EN to chain pings continuously until abort or reset.
module ping_sequencer #(
  parameter int unsigned NUM_TRANSMITTERS = 4,
  parameter int unsigned CLK_FREQ         = 100000000,
  parameter int unsigned TARGET_FREQ      = 40000,
  parameter int unsigned BURST_PERIODS    = 8,
  parameter int unsigned GUARD_CYCLES     = 100000,
  parameter int unsigned LISTEN_CYCLES    = 3000000,
  parameter int unsigned TOF_WIDTH        = 32
) (
  input logic   clk_in,
  input logic   rst_in,
  ping_if.slave bus
);

  localparam logic [63:0] BurstLen = 64'(BURST_PERIODS) * 64'(CLK_FREQ) / 64'(TARGET_FREQ);
  localparam logic [TOF_WIDTH-1:0] BurstEnd  = TOF_WIDTH'(BurstLen - 64'd1);
  localparam logic [TOF_WIDTH-1:0] GuardEnd  = TOF_WIDTH'(BurstLen + 64'(GUARD_CYCLES) - 64'd1);
  localparam logic [TOF_WIDTH-1:0] ListenEnd =
      TOF_WIDTH'(BurstLen + 64'(GUARD_CYCLES) + 64'(LISTEN_CYCLES) - 64'd1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StBurst  = 2'd1;
  localparam logic [1:0] StGuard  = 2'd2;
  localparam logic [1:0] StListen = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [TOF_WIDTH-1:0]        elapsed_q, elapsed_d;
  logic [NUM_TRANSMITTERS-1:0] tx_q, tx_d;
  logic [TOF_WIDTH-1:0]        tof_q, tof_d;
  logic                        tof_valid_q, tof_valid_d;
  logic                        tof_timeout_q, tof_timeout_d;
  logic                        captured_q, captured_d;
  logic                        rx_prev_q, rx_prev_d;
  logic                        echo_edge;

  assign echo_edge = bus.rx_echo_in & ~rx_prev_q;

  always_comb begin
    state_d       = state_q;
    elapsed_d     = elapsed_q;
    tx_d          = '0;
    tof_d         = tof_q;
    tof_valid_d   = 1'b0;
    tof_timeout_d = 1'b0;
    captured_d    = captured_q;
    rx_prev_d     = bus.rx_echo_in;

    case (state_q)
      StIdle: begin
        if (bus.trigger_in) begin
          state_d    = StBurst;
          elapsed_d  = '0;
          captured_d = 1'b0;
        end
      end
      StBurst: begin
        elapsed_d = elapsed_q + 1'b1;
        tx_d      = bus.tx_in;
        if (elapsed_q == BurstEnd) state_d = StGuard;
      end
      StGuard: begin
        elapsed_d = elapsed_q + 1'b1;
        if (elapsed_q == GuardEnd) state_d = StListen;
      end
      default: begin
        elapsed_d = elapsed_q + 1'b1;
        if (echo_edge && !captured_q) begin
          captured_d  = 1'b1;
          tof_d       = elapsed_q;
          tof_valid_d = 1'b1;
        end
        if (elapsed_q == ListenEnd) begin
          // A capture on this very cycle already produced the ping's strobe.
          if (!captured_q && !echo_edge) begin
            tof_d         = '1;
            tof_valid_d   = 1'b1;
            tof_timeout_d = 1'b1;
          end
`ifdef PING_AUTO_REPEAT_EN
          state_d    = StBurst;
          elapsed_d  = '0;
          captured_d = 1'b0;
`else
          state_d   = StIdle;
          elapsed_d = '0;
`endif
        end
      end
    endcase

    // Abort wins over every transition and suppresses this cycle's result.
    if (bus.abort_in && state_q != StIdle) begin
      state_d       = StIdle;
      elapsed_d     = '0;
      tx_d          = '0;
      tof_d         = tof_q;
      tof_valid_d   = 1'b0;
      tof_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      elapsed_q     <= '0;
      tx_q          <= '0;
      tof_q         <= '0;
      tof_valid_q   <= 1'b0;
      tof_timeout_q <= 1'b0;
      captured_q    <= 1'b0;
      rx_prev_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      elapsed_q     <= elapsed_d;
      tx_q          <= tx_d;
      tof_q         <= tof_d;
      tof_valid_q   <= tof_valid_d;
      tof_timeout_q <= tof_timeout_d;
      captured_q    <= captured_d;
      rx_prev_q     <= rx_prev_d;
    end
  end

  assign bus.tx_out          = tx_q;
  assign bus.busy_out        = (state_q != StIdle);
  assign bus.tof_out         = tof_q;
  assign bus.tof_valid_out   = tof_valid_q;
  assign bus.tof_timeout_out = tof_timeout_q;

endmodule

// File: tb/tb_ping_sequencer.sv
// Scoreboard bench for ping_sequencer: BURST_LEN=50, GUARD=20, LISTEN=100 (ping = 170 clocks).
module tb_ping_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [31:0] tof;
    logic        timeout;
    int unsigned at;
  } exp_t;
  exp_t sb[$];

  ping_if #(.NUM_TRANSMITTERS(4), .TOF_WIDTH(32)) p ();

  ping_sequencer #(
    .NUM_TRANSMITTERS(4),
    .CLK_FREQ        (1000000),
    .TARGET_FREQ     (40000),
    .BURST_PERIODS   (2),
    .GUARD_CYCLES    (20),
    .LISTEN_CYCLES   (100),
    .TOF_WIDTH       (32)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && p.tof_valid_out) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: cycle=%0d tof=%0h, required no strobe", cyc, p.tof_out);
      end else begin
        e = sb.pop_front();
        if (p.tof_out !== e.tof || p.tof_timeout_out !== e.timeout || cyc != e.at) begin
          bad++;
          $display("FAIL strobe: got tof=%0h timeout=%0b cycle=%0d, required tof=%0h timeout=%0b cycle=%0d",
                   p.tof_out, p.tof_timeout_out, cyc, e.tof, e.timeout, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: cycle=%0d got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_strobe(input logic [31:0] tof, input logic timeout, input int unsigned at);
    exp_t e;
    e.tof = tof;
    e.timeout = timeout;
    e.at = at;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge of the first BURST cycle (elapsed 0).
  task automatic start_ping(output int unsigned t);
    p.trigger_in = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    p.trigger_in = 1'b0;
  endtask

  // Drive rx high for elapsed in [a0,a1) or [b0,b1), for len cycles.
  task automatic run_ping(input int a0, input int a1, input int b0, input int b1, input int len);
    for (int e = 0; e < len; e++) begin
      p.rx_echo_in = (e >= a0 && e < a1) || (e >= b0 && e < b1);
      @(negedge clk);
    end
    p.rx_echo_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int unsigned t;
    logic [3:0]  prev_tx;
    p.tx_in = '0;
    p.trigger_in = 1'b0;
    p.abort_in = 1'b0;
    p.rx_echo_in = 1'b0;
    idle(3);
    check("rst_busy", 32'(p.busy_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_tx", 32'(p.tx_out), 32'd0);
    check("reset_busy", 32'(p.busy_out), 32'd0);
    check("reset_tof", p.tof_out, 32'd0);
    check("reset_valid", 32'(p.tof_valid_out), 32'd0);
    check("reset_timeout", 32'(p.tof_timeout_out), 32'd0);

`ifdef PING_AUTO_REPEAT_EN
    p.tx_in = 4'hF;
    start_ping(t);
    expect_strobe(32'hFFFF_FFFF, 1'b1, t + 170);
    expect_strobe(32'hFFFF_FFFF, 1'b1, t + 340);
    expect_strobe(32'hFFFF_FFFF, 1'b1, t + 510);
    for (int e = 0; e < 520; e++) begin
      check("auto_busy", 32'(p.busy_out), 32'd1);
      if (e == 171 || e == 220) check("auto_tx_on", 32'(p.tx_out), 32'hF);
      if (e == 221) check("auto_tx_off", 32'(p.tx_out), 32'h0);
      @(negedge clk);
    end
    p.abort_in = 1'b1;
    @(negedge clk);
    p.abort_in = 1'b0;
    check("auto_abort_busy", 32'(p.busy_out), 32'd0);
    idle(200);
    check("auto_stays_idle", 32'(p.busy_out), 32'd0);
`else
    // Burst gating, busy length, ignored triggers, timeout.
    prev_tx = '0;
    start_ping(t);
    expect_strobe(32'hFFFF_FFFF, 1'b1, t + 170);
    for (int e = 0; e < 180; e++) begin
      check("busy", 32'(p.busy_out), (e < 170) ? 32'd1 : 32'd0);
      check("tx_gate", 32'(p.tx_out), (e >= 1 && e <= 50) ? 32'(prev_tx) : 32'd0);
      prev_tx = 4'($urandom);
      p.tx_in = prev_tx;
      p.trigger_in = (e == 10 || e == 120);
      @(negedge clk);
    end
    p.trigger_in = 1'b0;

    // Echo at 100 captured, second edge at 130 ignored.
    start_ping(t);
    expect_strobe(32'd100, 1'b0, t + 101);
    run_ping(100, 110, 130, 140, 175);
    check("tof_hold", p.tof_out, 32'd100);
    check("timeout_low", 32'(p.tof_timeout_out), 32'd0);

    // Edge during guard held into listen: not an edge in listen.
    start_ping(t);
    expect_strobe(32'hFFFF_FFFF, 1'b1, t + 170);
    run_ping(60, 160, 0, 0, 175);

    // Edge on the last listen cycle is a capture.
    start_ping(t);
    expect_strobe(32'd169, 1'b0, t + 170);
    run_ping(169, 170, 0, 0, 170);
    // Back-to-back: trigger on first idle cycle; echo on first listen cycle.
    start_ping(t);
    expect_strobe(32'd70, 1'b0, t + 71);
    run_ping(70, 75, 0, 0, 175);

    // Abort at elapsed 30.
    p.tx_in = 4'hF;
    start_ping(t);
    idle(30);
    p.abort_in = 1'b1;
    @(negedge clk);
    p.abort_in = 1'b0;
    check("abort_busy", 32'(p.busy_out), 32'd0);
    check("abort_tx", 32'(p.tx_out), 32'd0);
    run_ping(100, 110, 0, 0, 200);

    // Reset mid-ping after a capture.
    start_ping(t);
    expect_strobe(32'd100, 1'b0, t + 101);
    run_ping(100, 110, 0, 0, 120);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(p.busy_out), 32'd0);
    check("midrst_tx", 32'(p.tx_out), 32'd0);
    check("midrst_tof", p.tof_out, 32'd0);
    check("midrst_valid", 32'(p.tof_valid_out), 32'd0);
    idle(100);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ping_sequencer.md
# ping_sequencer

Gates the continuously running per-element carrier from `transmit_beamformer` into finite ultrasonic bursts and measures the echo time-of-flight. Each ping runs burst → guard (ring-down blanking) → listen. The block sits between the beamformer outputs and the transducer drivers. It also takes the conditioned receive comparator line and reports one time-of-flight result per ping.

## Interface

Parameters:
- `NUM_TRANSMITTERS`, 4: number of gated carrier channels.
- `CLK_FREQ`, 100000000: system clock in Hz.
- `TARGET_FREQ`, 40000: carrier frequency in Hz.
- `BURST_PERIODS`, 8: carrier periods per burst. BURST_LEN = BURST_PERIODS*CLK_FREQ/TARGET_FREQ clocks, integer division.
- `GUARD_CYCLES`, 100000: blanking clocks after the burst; echoes are ignored here.
- `LISTEN_CYCLES`, 3000000: echo window in clocks.
- `TOF_WIDTH`, 32: width of the time-of-flight result.

Ports (one clock; reset is synchronous and active-high):
- `clk_in` input 1: system clock.
- `rst_in` input 1: synchronous, active-high reset.
- `tx_in` input [NUM_TRANSMITTERS-1:0]: beamformer carriers.
- `trigger_in` input 1: start a ping. Sampled only in IDLE.
- `abort_in` input 1: cancel the ping in progress.
- `rx_echo_in` input 1: echo comparator, already synchronised to `clk_in`.
- `tx_out` output [NUM_TRANSMITTERS-1:0]: gated carriers to the drivers.
- `busy_out` output 1: high whenever the state is not IDLE.
- `tof_out` output TOF_WIDTH: time-of-flight in clocks from burst start.
- `tof_valid_out` output 1: one-cycle strobe qualifying `tof_out`.
- `tof_timeout_out` output 1: set together with `tof_valid_out` when no echo was captured.

## Operation

- States: IDLE, BURST, GUARD, LISTEN. Counter `elapsed` is TOF_WIDTH bits wide and reads 0 on the first BURST cycle, incrementing by 1 every cycle of the ping.
- IDLE → BURST when `trigger_in` is high.
- BURST → GUARD at `elapsed` = BURST_LEN-1.
- GUARD → LISTEN at `elapsed` = BURST_LEN+GUARD_CYCLES-1.
- LISTEN → IDLE at `elapsed` = BURST_LEN+GUARD_CYCLES+LISTEN_CYCLES-1.
- `abort_in` high in any non-IDLE state: next state IDLE, with no `tof_valid_out` for that ping. `abort_in` takes priority over every other transition.
- `tx_out[i]` is the registered value of `tx_in[i]` while in BURST, and 0 otherwise.
- Echo detection: a rising edge is `rx_echo_in`=1 with the previous sample `rx_prev`=0. `rx_prev` updates every cycle in every state.
- Only the first rising edge during LISTEN is captured: `tof_out` ← `elapsed` on that cycle. Later edges in the same ping are ignored.
- LISTEN always runs its full length after a capture, so residual echoes cannot retrigger the next ping.
- Timeout: if there is no capture by the last LISTEN cycle, `tof_out` ← all ones and `tof_timeout_out` = 1.
- Exactly one `tof_valid_out` strobe per completed (non-aborted) ping.
- `trigger_in` outside IDLE is ignored, with no queuing.

## Timing

- Reset values:
  - state IDLE, `elapsed` 0.
  - `tx_out` 0, `busy_out` 0.
  - `tof_out` 0, `tof_valid_out` 0, `tof_timeout_out` 0.
  - `rx_prev` 1, so a line already high after reset is not an edge.
- Reset mid-ping behaves as an abort: all outputs return to their reset values on the next edge.
- `trigger_in` high at edge k puts the block in BURST from k+1. `busy_out` goes high at k+1, and `tx_out` follows `tx_in` with one cycle of latency from k+1.
- Capture edge at cycle c: `tof_valid_out` and `tof_out` are valid at c+1 for exactly one cycle. `tof_out` holds its value until the next strobe.
- Timeout strobe: one cycle after the last LISTEN cycle, coincident with the first IDLE cycle.
- An echo edge on the last LISTEN cycle counts as a capture, not a timeout.
- `trigger_in` on the first IDLE cycle after LISTEN starts a new ping; back-to-back pings are allowed.

## Configuration

- Macro `PING_AUTO_REPEAT_EN`.
- Defined: at the end of LISTEN the block goes straight to BURST with `elapsed` reset to 0, so pings run continuously. `busy_out` stays high across pings, and only `abort_in` or `rst_in` returns the block to IDLE.
- Undefined: it returns to IDLE after every ping.

## Test plan

Bench parameters: CLK_FREQ=1000000, TARGET_FREQ=40000, BURST_PERIODS=2 (BURST_LEN=50), GUARD_CYCLES=20, LISTEN_CYCLES=100.

- Trigger pulse with `tx_in` toggling: `tx_out` mirrors `tx_in` (1-cycle lag) for exactly 50 cycles, then stays 0; `busy_out` is high for 170 cycles.
- Echo rising at `elapsed`=100: one strobe, `tof_out`=100, `tof_timeout_out`=0; a second edge at 130 produces no strobe.
- No echo: a single strobe at the first IDLE cycle with `tof_out`=0xFFFFFFFF and `tof_timeout_out`=1.
- Echo edge at `elapsed`=60 (GUARD) held high into LISTEN: no capture, result is a timeout.
- `abort_in` at `elapsed`=30: IDLE next cycle, `tx_out`=0, no strobe. `trigger_in` pulses during busy are ignored.
- With `PING_AUTO_REPEAT_EN`: three consecutive pings with `elapsed` restarting at 0, three strobes spaced 170 cycles apart, stopped by `abort_in`.
